// File: rtl/exec_pipe_ctrl_if.sv
// Decode-stage and execution-stage signals exchanged with exec_pipe_ctrl.
// The master drives the ID instruction and EX flags. The slave returns control.
interface exec_pipe_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              valid_id;
  logic [4:0]        op_id;
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic [REG_AW-1:0] rd_id;
  logic [7:0]        target_id;
  logic [3:0]        flag_ex;

  logic [4:0]        op_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic              flush;
  logic              pc_load;
  logic [7:0]        pc_target;
  logic [3:0]        flags_q;

  modport master (
    output valid_id, op_id, rs_id, rt_id, rd_id, target_id, flag_ex,
    input  op_ex, fwd_a, fwd_b, stall, flush, pc_load, pc_target, flags_q
  );

  modport slave (
    input  valid_id, op_id, rs_id, rt_id, rd_id, target_id, flag_ex,
    output op_ex, fwd_a, fwd_b, stall, flush, pc_load, pc_target, flags_q
  );
endinterface

// File: rtl/exec_pipe_ctrl.sv
// EX-stage pipeline controller: opcode register, two-entry destination scoreboard,
// forwarding selects, load-use stall, branch redirect with fixed flush, and flags.
module exec_pipe_ctrl #(
  parameter int         REG_AW       = 3,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [4:0] NOP_OP       = 5'b11100
) (
  input  logic            clk,
  input  logic            reset,
  exec_pipe_ctrl_if.slave bus
);

  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_BZ    = 5'b10001;
  localparam logic [4:0] OP_STORE = 5'b10100;
  localparam logic [4:0] OP_LOAD  = 5'b10101;
  localparam logic [4:0] OP_IN    = 5'b10110;
  localparam logic [4:0] OP_OUT   = 5'b10111;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } ex_entry_t;

  // Load-ness only matters for the stall decision in EX, so WB keeps valid and rd.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } wb_entry_t;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  function automatic logic is_alu(input logic [4:0] op);
    return op[4] == 1'b0;
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return op inside {5'b11001, 5'b11010, 5'b11011};
  endfunction

  function automatic logic sets_flags(input logic [4:0] op);
    return is_alu(op) || is_shift(op) || (op == OP_IN);
  endfunction

  function automatic logic writes_rd(input logic [4:0] op);
    return sets_flags(op) || (op == OP_LOAD);
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    return is_alu(op) || is_shift(op) || (op == OP_STORE) || (op == OP_OUT);
  endfunction

  function automatic logic reads_rt(input logic [4:0] op);
    return (op[4:3] == 2'b00) || is_shift(op) || (op == OP_STORE);
  endfunction

  logic [4:0] op_ex_q, op_ex_d;
  logic [7:0] target_ex_q, target_ex_d;
  ex_entry_t  sb_ex_q, sb_ex_d;
  wb_entry_t  sb_wb_q, sb_wb_d;
  logic [3:0] flags_q, flags_d;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] pc_target_q, pc_target_d;

  logic a_ex, a_wb, b_ex, b_wb;
  logic stall, flush, pc_load, advance, branch_taken;

  // Hazard detection, forwarding and EX advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_ex = reads_rs(bus.op_id) && sb_ex_q.valid && (sb_ex_q.rd == bus.rs_id);
    a_wb = reads_rs(bus.op_id) && sb_wb_q.valid && (sb_wb_q.rd == bus.rs_id);
    b_ex = reads_rt(bus.op_id) && sb_ex_q.valid && (sb_ex_q.rd == bus.rt_id);
    b_wb = reads_rt(bus.op_id) && sb_wb_q.valid && (sb_wb_q.rd == bus.rt_id);

    stall   = bus.valid_id && sb_ex_q.is_load && (a_ex || b_ex) && !flush;
    advance = bus.valid_id && !stall && !flush;

    op_ex_d     = advance ? bus.op_id : NOP_OP;
    target_ex_d = advance ? bus.target_id : target_ex_q;
    sb_ex_d     = '0;
    if (advance) begin
      sb_ex_d.valid   = writes_rd(bus.op_id);
      sb_ex_d.rd      = bus.rd_id;
      sb_ex_d.is_load = (bus.op_id == OP_LOAD);
    end
    sb_wb_d = '{valid: sb_ex_q.valid, rd: sb_ex_q.rd};

    flags_d      = sets_flags(op_ex_q) ? bus.flag_ex : flags_q;
    branch_taken = (op_ex_q == OP_JMP) || ((op_ex_q == OP_BZ) && flags_q[1]);
  end

  always_comb begin
    bus.fwd_a = 2'b00;
    if (a_ex && !sb_ex_q.is_load) bus.fwd_a = 2'b01;
    else if (a_wb)                bus.fwd_a = 2'b10;

    bus.fwd_b = 2'b00;
    if (b_ex && !sb_ex_q.is_load) bus.fwd_b = 2'b01;
    else if (b_wb)                bus.fwd_b = 2'b10;
  end

  // Redirect FSM: next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_target_d = pc_target_q;
    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          state_d     = S_FLUSH;
          cnt_d       = CNT_INIT;
          pc_target_d = target_ex_q;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Redirect FSM: outputs. pc_load marks the first flush cycle only.
  always_comb begin
    flush   = (state_q == S_FLUSH);
    pc_load = flush && (cnt_q == CNT_INIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_ex_q     <= NOP_OP;
      target_ex_q <= '0;
      sb_ex_q     <= '0;
      sb_wb_q     <= '0;
      flags_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pc_target_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      op_ex_q     <= op_ex_d;
      target_ex_q <= target_ex_d;
      sb_ex_q     <= sb_ex_d;
      sb_wb_q     <= sb_wb_d;
      flags_q     <= flags_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_target_q <= pc_target_d;
    end
  end

  assign bus.op_ex     = op_ex_q;
  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.pc_load   = pc_load;
  assign bus.pc_target = pc_target_q;
  assign bus.flags_q   = flags_q;

endmodule

// File: tb/tb_exec_pipe_ctrl.sv
// Directed bench for exec_pipe_ctrl: cycle-by-cycle vector table with
// hand-derived expectations, plus reset and reset-during-flush sequences.
module tb_exec_pipe_ctrl;

  localparam logic [4:0] ADD   = 5'b00000;
  localparam logic [4:0] SUB   = 5'b00001;
  localparam logic [4:0] OR_   = 5'b00101;
  localparam logic [4:0] JMP   = 5'b10000;
  localparam logic [4:0] BZ    = 5'b10001;
  localparam logic [4:0] STORE = 5'b10100;
  localparam logic [4:0] LOAD  = 5'b10101;
  localparam logic [4:0] OUT   = 5'b10111;
  localparam logic [4:0] NOP   = 5'b11100;
  localparam int         NVEC  = 31;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  exec_pipe_ctrl_if #(.REG_AW(3)) bus ();

  exec_pipe_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .NOP_OP(5'b11100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic       valid;
    logic [4:0] op;
    logic [2:0] rs, rt, rd;
    logic [7:0] tgt;
    logic [3:0] fl;
    logic [4:0] e_op;
    logic [1:0] e_fa, e_fb;
    logic       e_stall, e_flush, e_pcl;
    logic [7:0] e_tgt;
    logic [3:0] e_flags;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic valid, input logic [4:0] op, input logic [2:0] rs, rt, rd,
    input logic [7:0] tgt, input logic [3:0] fl,
    input logic [4:0] e_op, input logic [1:0] e_fa, e_fb,
    input logic e_stall, e_flush, e_pcl, input logic [7:0] e_tgt, input logic [3:0] e_flags);
    vec_t v;
    v.valid = valid; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.tgt = tgt; v.fl = fl;
    v.e_op = e_op; v.e_fa = e_fa; v.e_fb = e_fb; v.e_stall = e_stall; v.e_flush = e_flush;
    v.e_pcl = e_pcl; v.e_tgt = e_tgt; v.e_flags = e_flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic valid, input logic [4:0] op, input logic [2:0] rs, rt, rd,
                       input logic [7:0] tgt, input logic [3:0] fl);
    bus.valid_id = valid; bus.op_id = op; bus.rs_id = rs; bus.rt_id = rt;
    bus.rd_id = rd; bus.target_id = tgt; bus.flag_ex = fl;
  endtask

  task automatic check_all(input string tag, input logic [4:0] e_op, input logic [1:0] e_fa, e_fb,
                           input logic e_stall, e_flush, e_pcl, input logic [7:0] e_tgt,
                           input logic [3:0] e_flags);
    check({tag, " op_ex"},     32'(bus.op_ex),     32'(e_op));
    check({tag, " fwd_a"},     32'(bus.fwd_a),     32'(e_fa));
    check({tag, " fwd_b"},     32'(bus.fwd_b),     32'(e_fb));
    check({tag, " stall"},     32'(bus.stall),     32'(e_stall));
    check({tag, " flush"},     32'(bus.flush),     32'(e_flush));
    check({tag, " pc_load"},   32'(bus.pc_load),   32'(e_pcl));
    check({tag, " pc_target"}, 32'(bus.pc_target), 32'(e_tgt));
    check({tag, " flags_q"},   32'(bus.flags_q),   32'(e_flags));
  endtask

  initial begin
    //                v  op     rs rt rd tgt    fl     op_ex fa fb st fl pl tgt    flags
    vecs[0]  = mk(1, ADD,   2, 3, 1, 8'h00, 4'h0,  NOP,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[1]  = mk(1, SUB,   1, 1, 2, 8'h00, 4'h0,  ADD,  1, 1, 0, 0, 0, 8'h00, 4'h0);
    vecs[2]  = mk(1, ADD,   4, 5, 1, 8'h00, 4'h0,  SUB,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[3]  = mk(0, NOP,   0, 0, 0, 8'h00, 4'h0,  ADD,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[4]  = mk(1, SUB,   1, 1, 2, 8'h00, 4'h0,  NOP,  2, 2, 0, 0, 0, 8'h00, 4'h0);
    vecs[5]  = mk(1, LOAD,  0, 0, 3, 8'h00, 4'h0,  SUB,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[6]  = mk(1, OR_,   3, 5, 4, 8'h00, 4'h0,  LOAD, 0, 0, 1, 0, 0, 8'h00, 4'h0);
    vecs[7]  = mk(1, OR_,   3, 5, 4, 8'h00, 4'h0,  NOP,  2, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[8]  = mk(1, ADD,   7, 7, 6, 8'h00, 4'h0,  OR_,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[9]  = mk(1, BZ,    0, 0, 0, 8'h40, 4'h2,  ADD,  0, 0, 0, 0, 0, 8'h00, 4'h0);
    vecs[10] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h0,  BZ,   0, 0, 0, 0, 0, 8'h00, 4'h2);
    vecs[11] = mk(1, ADD,   2, 3, 1, 8'h00, 4'h0,  NOP,  0, 0, 0, 1, 1, 8'h40, 4'h2);
    vecs[12] = mk(1, ADD,   2, 3, 1, 8'h00, 4'h0,  NOP,  0, 0, 0, 1, 0, 8'h40, 4'h2);
    vecs[13] = mk(1, ADD,   2, 3, 1, 8'h00, 4'h0,  NOP,  0, 0, 0, 0, 0, 8'h40, 4'h2);
    vecs[14] = mk(1, BZ,    0, 0, 0, 8'h80, 4'h1,  ADD,  0, 0, 0, 0, 0, 8'h40, 4'h2);
    vecs[15] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h1,  BZ,   0, 0, 0, 0, 0, 8'h40, 4'h1);
    vecs[16] = mk(1, JMP,   0, 0, 0, 8'hF0, 4'h1,  NOP,  0, 0, 0, 0, 0, 8'h40, 4'h1);
    vecs[17] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h1,  JMP,  0, 0, 0, 0, 0, 8'h40, 4'h1);
    vecs[18] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h1,  NOP,  0, 0, 0, 1, 1, 8'hF0, 4'h1);
    vecs[19] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h1,  NOP,  0, 0, 0, 1, 0, 8'hF0, 4'h1);
    vecs[20] = mk(0, NOP,   0, 0, 0, 8'h00, 4'h1,  NOP,  0, 0, 0, 0, 0, 8'hF0, 4'h1);
    vecs[21] = mk(1, JMP,   0, 0, 0, 8'h22, 4'h1,  NOP,  0, 0, 0, 0, 0, 8'hF0, 4'h1);
    vecs[22] = mk(1, LOAD,  0, 0, 5, 8'h00, 4'h1,  JMP,  0, 0, 0, 0, 0, 8'hF0, 4'h1);
    vecs[23] = mk(1, OR_,   5, 5, 4, 8'h00, 4'h1,  LOAD, 0, 0, 0, 1, 1, 8'h22, 4'h1);
    vecs[24] = mk(1, OR_,   5, 5, 4, 8'h00, 4'h1,  NOP,  2, 2, 0, 1, 0, 8'h22, 4'h1);
    vecs[25] = mk(1, OR_,   5, 5, 4, 8'h00, 4'h1,  NOP,  0, 0, 0, 0, 0, 8'h22, 4'h1);
    vecs[26] = mk(1, ADD,   2, 3, 1, 8'h00, 4'h1,  OR_,  0, 0, 0, 0, 0, 8'h22, 4'h1);
    vecs[27] = mk(1, ADD,   2, 3, 1, 8'h00, 4'h1,  ADD,  0, 0, 0, 0, 0, 8'h22, 4'h1);
    vecs[28] = mk(1, SUB,   1, 1, 2, 8'h00, 4'h1,  ADD,  1, 1, 0, 0, 0, 8'h22, 4'h1);
    vecs[29] = mk(1, STORE, 1, 2, 0, 8'h00, 4'h1,  SUB,  2, 1, 0, 0, 0, 8'h22, 4'h1);
    vecs[30] = mk(1, OUT,   2, 2, 0, 8'h00, 4'h1,  STORE,2, 0, 0, 0, 0, 8'h22, 4'h1);

    // Reset held for three cycles while the inputs toggle.
    reset = 1'b0;
    drive(0, NOP, 0, 0, 0, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 4'($urandom));
      @(negedge clk);
      check_all($sformatf("reset[%0d]", i), NOP, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    end

    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].tgt, vecs[i].fl);
      @(negedge clk);
      check_all($sformatf("vec[%0d]", i), vecs[i].e_op, vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_stall,
                vecs[i].e_flush, vecs[i].e_pcl, vecs[i].e_tgt, vecs[i].e_flags);
      @(posedge clk); #1;
    end

    // Reset asserted during the second flush cycle of a JMP.
    drive(1, JMP, 0, 0, 0, 8'h99, 4'h1);
    @(posedge clk); #1;
    drive(0, NOP, 0, 0, 0, 8'h00, 4'h1);
    @(negedge clk);
    check("midrst jmp in ex", 32'(bus.op_ex), 32'(JMP));
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst flush1", 32'(bus.flush), 32'd1);
    check("midrst pc_load1", 32'(bus.pc_load), 32'd1);
    check("midrst target", 32'(bus.pc_target), 32'h99);
    @(posedge clk); #1;
    drive(1, LOAD, 0, 0, 5, 8'h00, 4'h1);
    @(negedge clk);
    check("midrst flush2", 32'(bus.flush), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_all("midrst async", NOP, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, ADD, 2, 3, 1, 8'h00, 4'h1);
    @(negedge clk);
    check("post-rst flush", 32'(bus.flush), 32'd0);
    check("post-rst op_ex", 32'(bus.op_ex), 32'(NOP));
    @(posedge clk); #1;
    drive(0, NOP, 0, 0, 0, 8'h00, 4'h1);
    @(negedge clk);
    check("post-rst advance", 32'(bus.op_ex), 32'(ADD));
    check("post-rst idle", 32'(bus.flush), 32'd0);
    check("post-rst pc_load", 32'(bus.pc_load), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
